// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit payment block.
// Contents: FSM state enum, default fee width, coin value constants,
// coin_code-to-value decode and the number of parking slots.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        GATE    = 2'd2
    } state_t;

    localparam int FEE_W_DEF = 11;
    localparam int NUM_SLOTS = 6;

    localparam logic [4:0] COIN_1  = 5'd1;
    localparam logic [4:0] COIN_5  = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_20 = 5'd20;

    function automatic logic [4:0] coin_value(input logic [1:0] code);
        logic [4:0] v;
        case (code)
            2'd0:    v = COIN_1;
            2'd1:    v = COIN_5;
            2'd2:    v = COIN_10;
            default: v = COIN_20;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/parking_down_counter.sv
// Loadable down-counter with a zero flag, used for the gate-open timer and
// the optional collection timeout timer.
// Ports: clk, rst (sync, active-high), load/load_val (load has priority),
// dec (decrement, saturates at 0), zero (count == 0).
module parking_down_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/parking_exit_payment.sv
// Exit-side payment controller: takes the check-out fee, collects coins until
// the fee is covered, reports change, holds the gate open for GATE_CYCLES and
// pulses a slot release when the gate closes.
// Optional macro PARK_PAY_TIMEOUT_EN: abort COLLECT after TIMEOUT_CYCLES
// coin-free cycles with a full refund; when undefined, aborted is tied to 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fee_valid, fee, slot      check-out strobe with fee owed and slot number
//   coin_valid, coin_code     coin strobe and code (0:1 1:5 2:10 3:20)
//   busy                      not IDLE
//   remaining                 fee minus paid, floored at 0
//   change, change_valid      change amount and its one-cycle pulse
//   gate_open                 high throughout GATE
//   release_valid/slot        slot release pulse on the last GATE cycle
//   aborted                   timeout abort pulse
module parking_exit_payment
    import parking_pkg::*;
#(
    parameter int FEE_W          = FEE_W_DEF,
    parameter int GATE_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fee_valid,
    input  logic [FEE_W-1:0] fee,
    input  logic [3:0]       slot,
    input  logic             coin_valid,
    input  logic [1:0]       coin_code,
    output logic             busy,
    output logic [FEE_W-1:0] remaining,
    output logic [FEE_W-1:0] change,
    output logic             change_valid,
    output logic             gate_open,
    output logic             release_valid,
    output logic [3:0]       release_slot,
    output logic             aborted
);

    localparam int GW = $clog2(GATE_CYCLES + 1);

    state_t           state, state_nx;
    logic [FEE_W:0]   paid, paid_sum, over;
    logic [FEE_W-1:0] fee_r;
    logic [3:0]       slot_r;
    logic             coin_hit, paid_done;
    logic             gate_load, gate_zero, gate_last;
    logic             timeout_hit;

    // Coins only count in COLLECT; paid is one bit wider than the fee so the
    // final coin can overshoot without wrapping.
    assign coin_hit  = (state == COLLECT) && coin_valid;
    assign paid_sum  = paid + (coin_hit ? (FEE_W+1)'(coin_value(coin_code)) : '0);
    assign paid_done = (paid_sum >= {1'b0, fee_r});
    assign over      = paid_sum - {1'b0, fee_r};

    // Gate timer is loaded with GATE_CYCLES-1 on entry; zero marks the last
    // open cycle.
    assign gate_load = (state != GATE) && (state_nx == GATE);
    assign gate_last = (state == GATE) && gate_zero;

    parking_down_counter #(.W(GW)) u_gate_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (gate_load),
        .load_val (GW'(GATE_CYCLES - 1)),
        .dec      (state == GATE),
        .zero     (gate_zero)
    );

`ifdef PARK_PAY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic tmo_zero;

    // Restarted on COLLECT entry and on every coin; a coin in the expiry
    // cycle wins over the abort.
    parking_down_counter #(.W(TW)) u_tmo_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (((state != COLLECT) && (state_nx == COLLECT)) || coin_hit),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .dec      (state == COLLECT),
        .zero     (tmo_zero)
    );

    assign timeout_hit = (state == COLLECT) && !coin_hit && tmo_zero;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fee_valid) state_nx = (fee == '0) ? GATE : COLLECT;
            COLLECT: begin
                if (paid_done)        state_nx = GATE;
                else if (timeout_hit) state_nx = IDLE;
            end
            GATE:    if (gate_zero) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            paid         <= '0;
            fee_r        <= '0;
            slot_r       <= '0;
            remaining    <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            aborted      <= 1'b0;
            case (state)
                IDLE: begin
                    if (fee_valid) begin
                        fee_r     <= fee;
                        slot_r    <= slot;
                        paid      <= '0;
                        remaining <= fee;
                        if (fee == '0) begin
                            change       <= '0;
                            change_valid <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    paid <= paid_sum;
                    remaining <= paid_done ? '0 : (fee_r - paid_sum[FEE_W-1:0]);
                    if (paid_done) begin
                        change       <= over[FEE_W-1:0];
                        change_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        // paid < fee_r here, so it fits in FEE_W bits
                        change       <= paid[FEE_W-1:0];
                        change_valid <= 1'b1;
                        aborted      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign gate_open     = (state == GATE);
    assign release_valid = gate_last;
    assign release_slot  = gate_last ? slot_r : 4'd0;

endmodule

// File: tb/tb_parking_exit_payment.sv
module tb_parking_exit_payment;

    localparam int FEE_W = 11;
    localparam int GC    = 20;
    localparam int TC    = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             fee_valid;
    logic [FEE_W-1:0] fee;
    logic [3:0]       slot;
    logic             coin_valid;
    logic [1:0]       coin_code;
    logic             busy;
    logic [FEE_W-1:0] remaining;
    logic [FEE_W-1:0] change;
    logic             change_valid;
    logic             gate_open;
    logic             release_valid;
    logic [3:0]       release_slot;
    logic             aborted;

    int checks = 0;
    int errors = 0;
    int coin_q[$];

    parking_exit_payment #(.FEE_W(FEE_W), .GATE_CYCLES(GC), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .fee_valid(fee_valid), .fee(fee), .slot(slot),
        .coin_valid(coin_valid), .coin_code(coin_code), .busy(busy),
        .remaining(remaining), .change(change), .change_valid(change_valid),
        .gate_open(gate_open), .release_valid(release_valid),
        .release_slot(release_slot), .aborted(aborted)
    );

    always #5 clk = ~clk;

    function automatic int coin_amt(input int code);
        case (code)
            0: return 1;
            1: return 5;
            2: return 10;
            default: return 20;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction against the model: fee capture, coins (from coin_q,
    // then random), gate duration, single change pulse and slot release.
    task automatic run_txn(input int f, input int s, input int gap_max,
                           input bit inject_fee, input string name);
        int paid = 0;
        int exp_rem, code, g, cnt, cv, guard;
        bit first = 1;
        fee_valid = 1; fee = f[FEE_W-1:0]; slot = s[3:0];
        coin_valid = 1; coin_code = 2'(3);   // dropped: same cycle as fee
        step();
        fee_valid = 0; coin_valid = 0;
        checks++;
        if (f == 0) begin
            if (gate_open !== 1'b1 || change_valid !== 1'b1 || change !== 0) begin
                errors++;
                $display("FAIL %s zero_fee: gate=%0b cv=%0b change=%0d want 1 1 0", name, gate_open, change_valid, change);
            end
        end else begin
            if (busy !== 1'b1 || gate_open !== 1'b0 || remaining !== f[FEE_W-1:0]) begin
                errors++;
                $display("FAIL %s capture: busy=%0b gate=%0b rem=%0d want 1 0 %0d", name, busy, gate_open, remaining, f);
            end
        end
        while (paid < f) begin
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int i = 0; i < g; i++) step();
            code = (coin_q.size() > 0) ? coin_q.pop_front() : $urandom_range(3, 0);
            coin_valid = 1; coin_code = code[1:0];
            if (inject_fee && first) begin
                fee_valid = 1; fee = 11'd99; slot = 4'd2;
            end
            first = 0;
            step();
            coin_valid = 0; fee_valid = 0;
            paid += coin_amt(code);
            exp_rem = (f > paid) ? f - paid : 0;
            checks++;
            if (remaining !== exp_rem[FEE_W-1:0]) begin
                errors++;
                $display("FAIL %s remaining: got %0d want %0d", name, remaining, exp_rem);
            end
            checks++;
            if (paid >= f) begin
                if (gate_open !== 1'b1 || change_valid !== 1'b1 || change !== 11'((paid - f) & 2047)) begin
                    errors++;
                    $display("FAIL %s change: gate=%0b cv=%0b change=%0d want 1 1 %0d", name, gate_open, change_valid, change, paid - f);
                end
            end else if (gate_open !== 1'b0 || change_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s early_gate: gate=%0b cv=%0b want 0 0", name, gate_open, change_valid);
            end
        end
        cnt = gate_open ? 1 : 0;
        cv = change_valid ? 1 : 0;
        guard = 0;
        while (!release_valid && guard < GC + 5) begin
            coin_valid = $urandom_range(1, 0); coin_code = 2'($urandom_range(3, 0));
            step();
            guard++;
            if (gate_open) cnt++;
            if (change_valid) cv++;
        end
        coin_valid = 0;
        checks++;
        if (release_valid !== 1'b1 || release_slot !== s[3:0] || cnt != GC || cv != 1) begin
            errors++;
            $display("FAIL %s gate: rel=%0b slot=%0d open=%0d cv=%0d want 1 %0d %0d 1", name, release_valid, release_slot, cnt, cv, s, GC);
        end
        step();
        checks++;
        if (busy !== 1'b0 || gate_open !== 1'b0 || release_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s close: busy=%0b gate=%0b rel=%0b want 0 0 0", name, busy, gate_open, release_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1; fee_valid = 0; fee = '0; slot = '0; coin_valid = 0; coin_code = '0;
        step(); step();
        rst = 0;
        checks++;
        if ({busy, gate_open, change_valid, release_valid, aborted} !== 5'b0 ||
            remaining !== 0 || change !== 0 || release_slot !== 0) begin
            errors++;
            $display("FAIL reset: busy=%0b gate=%0b cv=%0b rel=%0b ab=%0b rem=%0d chg=%0d rs=%0d want all 0",
                     busy, gate_open, change_valid, release_valid, aborted, remaining, change, release_slot);
        end
        coin_valid = 1; coin_code = 2'd3;
        step();
        coin_valid = 0;
        checks++;
        if (busy !== 1'b0 || remaining !== 0) begin
            errors++;
            $display("FAIL idle_coin: busy=%0b rem=%0d want 0 0", busy, remaining);
        end
    endtask

    task automatic test_exact_pay();
        coin_q = '{3, 2, 1, 0, 0};
        run_txn(37, 3, 0, 0, "exact37");
    endtask

    task automatic test_change();
        coin_q = '{2, 1};
        run_txn(12, 5, 1, 0, "change12");
    endtask

    task automatic test_fee_zero();
        run_txn(0, 1, 0, 0, "fee0");
    endtask

    task automatic test_fee_while_busy();
        coin_q = '{2, 2};
        run_txn(20, 4, 2, 1, "busy_fee");
    endtask

    task automatic test_rst_mid_gate();
        int rel = 0;
        fee_valid = 1; fee = 11'd5; slot = 4'd6;
        step();
        fee_valid = 0; coin_valid = 1; coin_code = 2'd1;
        step();
        coin_valid = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (gate_open !== 1'b0 || busy !== 1'b0 || release_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_gate: gate=%0b busy=%0b rel=%0b want 0 0 0", gate_open, busy, release_valid);
        end
        for (int i = 0; i < GC + 5; i++) begin
            step();
            if (release_valid || gate_open) rel++;
        end
        checks++;
        if (rel != 0) begin
            errors++;
            $display("FAIL rst_no_release: active cycles %0d want 0", rel);
        end
        coin_q = '{1, 0, 0, 0};
        run_txn(8, 2, 1, 0, "after_rst");
    endtask

    task automatic test_random();
        coin_q.delete();
        run_txn(2047, 7, 0, 0, "max_fee");
        for (int n = 0; n < 6; n++)
            run_txn($urandom_range(150, 0), $urandom_range(15, 0), 3, $urandom_range(1, 0), "random");
    endtask

    task automatic test_timeout();
        int n = 0;
        int gates = 0;
        fee_valid = 1; fee = 11'd30; slot = 4'd3;
        step();
        fee_valid = 0; coin_valid = 1; coin_code = 2'd2;
        step();
        coin_valid = 0;
`ifdef PARK_PAY_TIMEOUT_EN
        while (!aborted && n < TC + 20) begin
            step();
            n++;
            if (gate_open) gates++;
        end
        checks++;
        if (aborted !== 1'b1 || n != TC || change_valid !== 1'b1 || change !== 10 || gates != 0 || release_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout: ab=%0b after %0d cv=%0b chg=%0d gates=%0d want 1 %0d 1 10 0", aborted, n, change_valid, change, gates, TC);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%0b want 0", busy);
        end
`else
        for (int i = 0; i < 1000; i++) begin
            step();
            if (gate_open || aborted || !busy) gates++;
        end
        checks++;
        if (gates != 0 || remaining !== 20) begin
            errors++;
            $display("FAIL no_timeout: bad cycles=%0d rem=%0d want 0 20", gates, remaining);
        end
        rst = 1;
        step();
        rst = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_change();
        test_fee_zero();
        test_fee_while_busy();
        test_rst_mid_gate();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_exit_payment.md
Name: parking_exit_payment

Overview:
Exit-side payment controller for the parking system. It consumes the fee produced at check-out, accepts coin entries until the fee is covered, and reports the change. It then opens the exit gate for a fixed time and pulses a slot-release back to the slot/occupancy logic. It sits between the check-in/out timekeeping block and the gate actuator and display.

Parameters:
FEE_W, 11, width of fee, paid and change values (matches the check-in/out time width)
GATE_CYCLES, 500, clk cycles the gate stays open
TIMEOUT_CYCLES, 10000, idle cycles in COLLECT before abort (only with PARK_PAY_TIMEOUT_EN)

Ports:
clk  in  1  single system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
fee_valid  in  1  one-cycle strobe: fee and slot are valid
fee  in  FEE_W  amount owed
slot  in  4  slot number 1..6 that is checking out
coin_valid  in  1  one-cycle strobe per inserted coin
coin_code  in  2  coin value: 0 means 1, 1 means 5, 2 means 10, 3 means 20
busy  out  1  high in any state except IDLE
remaining  out  FEE_W  fee minus paid, floored at 0, for the display
change  out  FEE_W  paid minus fee; valid while change_valid is high
change_valid  out  1  one-cycle pulse on entry to GATE
gate_open  out  1  high throughout GATE
release_valid  out  1  one-cycle pulse when the gate closes
release_slot  out  4  slot to free; valid with release_valid
aborted  out  1  one-cycle pulse on timeout abort (0 when the feature is absent)

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. All outputs and internal registers (paid, fee_r, slot_r, counters) are 0.
- States: IDLE, COLLECT, GATE.
- IDLE:
  - On fee_valid, capture fee_r=fee, slot_r=slot and clear paid.
  - If fee==0, go to GATE next cycle with change=0. Otherwise go to COLLECT.
  - coin_valid in IDLE is ignored (no credit).
- COLLECT:
  - On coin_valid, paid += coin value. paid is FEE_W+1 bits, so it cannot overflow: max is 2047+19.
  - When paid (including a coin arriving this cycle) ≥ fee_r, go to GATE on the next cycle. change = paid − fee_r, truncated to FEE_W.
  - remaining = fee_r − paid, registered, updated the cycle after each coin.
  - fee_valid while busy is ignored; no queueing.
- GATE:
  - gate_open=1 for exactly GATE_CYCLES cycles.
  - change_valid pulses in the first GATE cycle.
  - In the last GATE cycle, release_valid=1 and release_slot=slot_r; return to IDLE the next cycle.
  - Coins during GATE are ignored.
- fee_valid and coin_valid in the same IDLE cycle: the fee is captured, the coin is dropped.
- Slot values outside 1..6 are passed through unchanged; no checking.
- rst asserted mid-COLLECT or mid-GATE: immediate return to IDLE. The gate closes and no release is issued.

Optional Feature:
PARK_PAY_TIMEOUT_EN:
- Defined: an idle counter runs in COLLECT and is cleared on each coin_valid. When it reaches TIMEOUT_CYCLES, aborted pulses, change=paid (full refund) with change_valid pulsed, and the state returns to IDLE without opening the gate or issuing a release.
- Undefined: COLLECT waits indefinitely; aborted is tied to 0 and the counter is not built.

Decomposition:
- Package parking_pkg holds:
  - state enum (IDLE, COLLECT, GATE)
  - FEE_W default
  - coin value constants (COIN_1/5/10/20) and a coin_code-to-value function
  - slot count constant (6)
- One natural sub-module, parking_down_counter: loadable down-counter with a zero flag. It is reused for the gate timer and the timeout timer.

Test Plan:
1. fee_valid with fee=37, slot=3; coins 20, 10, 5, 1, 1 → remaining steps 17, 7, 2, 1, 0. GATE entered with change=0; gate_open lasts GATE_CYCLES; release_valid with release_slot=3.
2. fee=12, slot=5; coins 10, 5 → change=3 and change_valid pulses once; release_slot=5.
3. fee=0, slot=1 → no COLLECT cycles; GATE directly, change=0.
4. fee_valid during COLLECT (fee=99, slot=2) → ignored; original fee_r and slot_r are retained; coins during GATE are not credited.
5. rst asserted mid-GATE → gate_open=0 next cycle, no release_valid, busy=0. A new fee=8 transaction then completes normally.
6. With PARK_PAY_TIMEOUT_EN and TIMEOUT_CYCLES=50: fee=30, one coin of 10, then silence → aborted after 50 idle cycles, change=10, no gate_open. Without the macro: still in COLLECT after 1000 cycles.
